// File: rtl/quic_bit_window.sv
// QUIC bit aligner: 64-bit buffer presenting an MSB-aligned 32-bit window, advanced 0..32 bits/cycle.
// Window reflects consume/refill 1 cycle later; word_ready only while <=32 bits are buffered.
module quic_bit_window (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    input  logic        consume_en,
    input  logic [5:0]  consume_len,
    output logic [31:0] bitstream_output,
    output logic        window_valid,
    output logic [6:0]  bit_count,
    output logic [31:0] consumed_total,
    output logic        err
);

    logic [63:0] r_buf;
    logic [6:0]  r_bits;
    logic [31:0] r_consumed;
    logic        r_err;

    logic        w_legal;
    logic        w_illegal;
    logic [6:0]  w_len;
    logic [63:0] w_buf_s;
    logic [6:0]  w_bits_s;
    logic        w_accept;
    logic [63:0] w_ins;

    assign window_valid     = (r_bits >= 7'd32);
    assign word_ready       = (r_bits <= 7'd32);
    assign bitstream_output = r_buf[63:32];
    assign bit_count        = r_bits;
    assign consumed_total   = r_consumed;
    assign err              = r_err;

    assign w_legal   = consume_en && window_valid && (consume_len <= 6'd32);
    assign w_illegal = consume_en && !w_legal;
    assign w_len     = w_legal ? {1'b0, consume_len} : 7'd0;
    assign w_buf_s   = r_buf << w_len;
    assign w_bits_s  = r_bits - w_len;
    assign w_accept  = word_valid && word_ready;
    // New word lands directly behind the residue left after this cycle's consume.
    assign w_ins     = {word_data, 32'b0} >> w_bits_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= 64'd0;
            r_bits     <= 7'd0;
            r_consumed <= 32'd0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_buf      <= 64'd0;
            r_bits     <= 7'd0;
            r_consumed <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf  <= w_buf_s | w_ins;
                r_bits <= w_bits_s + 7'd32;
            end else begin
                r_buf  <= w_buf_s;
                r_bits <= w_bits_s;
            end
            r_consumed <= r_consumed + {25'd0, w_len};
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quic_bit_window.sv
// Directed bench for quic_bit_window with a bit-serial golden model for the mixed-length run.
module tb_quic_bit_window;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        consume_en;
    logic [5:0]  consume_len;
    logic [31:0] bitstream_output;
    logic        window_valid;
    logic [6:0]  bit_count;
    logic [31:0] consumed_total;
    logic        err;

    int checks;
    int failures;

    logic [31:0] stream [0:63];
    int          m_bits;
    int          m_cons;
    int          m_wi;
    int          m_len;

    quic_bit_window dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .word_valid       (word_valid),
        .word_data        (word_data),
        .word_ready       (word_ready),
        .consume_en       (consume_en),
        .consume_len      (consume_len),
        .bitstream_output (bitstream_output),
        .window_valid     (window_valid),
        .bit_count        (bit_count),
        .consumed_total   (consumed_total),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_win"},   64'(bitstream_output), 64'h0);
        chk({tag, "_wvld"},  64'(window_valid),     64'h0);
        chk({tag, "_wrdy"},  64'(word_ready),       64'h1);
        chk({tag, "_bits"},  64'(bit_count),        64'h0);
        chk({tag, "_total"}, 64'(consumed_total),   64'h0);
        chk({tag, "_err"},   64'(err),              64'h0);
    endtask

    function automatic logic [31:0] gold(input int off);
        logic [31:0] g;
        logic [31:0] w;
        int p;
        g = '0;
        for (int k = 0; k < 32; k++) begin
            p = off + k;
            w = stream[p / 32];
            g[31 - k] = w[31 - (p % 32)];
        end
        return g;
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        clear       = 1'b0;
        word_valid  = 1'b0;
        word_data   = 32'h0;
        consume_en  = 1'b0;
        consume_len = 6'd0;
        for (int i = 0; i < 64; i++) stream[i] = $urandom;

        #12;
        chk_reset_state("reset");
        reset_n = 1'b1;
        step();

        // Fill: two words, second accepted at bits == 32.
        word_valid = 1'b1;
        word_data  = 32'hA5A5A5A5;
        step();
        chk("fill1_win",  64'(bitstream_output), 64'hA5A5A5A5);
        chk("fill1_bits", 64'(bit_count),        64'd32);
        chk("fill1_wvld", 64'(window_valid),     64'd1);
        chk("fill1_wrdy", 64'(word_ready),       64'd1);
        word_data = 32'h0F0F0F0F;
        step();
        chk("fill2_bits", 64'(bit_count),  64'd64);
        chk("fill2_wrdy", 64'(word_ready), 64'd0);
        word_valid = 1'b0;

        // Unaligned consume.
        consume_en  = 1'b1;
        consume_len = 6'd4;
        step();
        chk("c4_win",   64'(bitstream_output), 64'h5A5A5A50);
        chk("c4_bits",  64'(bit_count),        64'd60);
        chk("c4_total", 64'(consumed_total),   64'd4);
        consume_len = 6'd28;
        step();
        chk("c28_win",   64'(bitstream_output), 64'h0F0F0F0F);
        chk("c28_bits",  64'(bit_count),        64'd32);
        chk("c28_total", 64'(consumed_total),   64'd32);
        consume_en = 1'b0;

        // Clear, then sustained 32-bit streaming.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr1_bits",  64'(bit_count),      64'd0);
        chk("clr1_total", 64'(consumed_total), 64'd0);
        word_valid = 1'b1;
        word_data  = 32'd0;
        step();
        chk("str0_win", 64'(bitstream_output), 64'd0);
        consume_en  = 1'b1;
        consume_len = 6'd32;
        for (int i = 1; i <= 8; i++) begin
            word_data = 32'(i);
            step();
            chk("str_win",  64'(bitstream_output), 64'(i));
            chk("str_wvld", 64'(window_valid),     64'd1);
            chk("str_bits", 64'(bit_count),        64'd32);
            chk("str_err",  64'(err),              64'd0);
        end
        consume_en = 1'b0;
        word_valid = 1'b0;

        // Mixed length 7 against the bit-serial model.
        clear = 1'b1;
        step();
        clear  = 1'b0;
        m_bits = 0;
        m_cons = 0;
        m_wi   = 0;
        for (int c = 0; c < 100; c++) begin
            m_len       = (m_bits >= 32) ? 7 : 0;
            consume_en  = (m_len != 0);
            consume_len = 6'd7;
            word_valid  = 1'b1;
            word_data   = stream[m_wi];
            chk("mix_wrdy", 64'(word_ready), 64'(m_bits <= 32));
            if (m_bits <= 32) begin
                m_bits = m_bits - m_len + 32;
                m_wi++;
            end else begin
                m_bits = m_bits - m_len;
            end
            m_cons += m_len;
            step();
            chk("mix_bits",  64'(bit_count),      64'(m_bits));
            chk("mix_total", 64'(consumed_total), 64'(m_cons));
            if (m_bits >= 32) chk("mix_win", 64'(bitstream_output), 64'(gold(m_cons)));
        end
        chk("mix_err", 64'(err), 64'd0);
        consume_en = 1'b0;
        word_valid = 1'b0;

        // Illegal consume with only 16 bits buffered.
        clear = 1'b1;
        step();
        clear      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'hDEADBEEF;
        step();
        word_valid  = 1'b0;
        consume_en  = 1'b1;
        consume_len = 6'd16;
        step();
        chk("i16_bits", 64'(bit_count),        64'd16);
        chk("i16_win",  64'(bitstream_output), 64'hBEEF0000);
        consume_len = 6'd5;
        step();
        consume_en = 1'b0;
        chk("ill5_err",   64'(err),              64'd1);
        chk("ill5_bits",  64'(bit_count),        64'd16);
        chk("ill5_win",   64'(bitstream_output), 64'hBEEF0000);
        chk("ill5_total", 64'(consumed_total),   64'd16);
        step();
        chk("ill5_sticky", 64'(err), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr2_err",  64'(err),       64'd0);
        chk("clr2_bits", 64'(bit_count), 64'd0);

        // Illegal consume_len 33 with a full buffer.
        word_valid = 1'b1;
        word_data  = 32'h01234567;
        step();
        word_data = 32'h89ABCDEF;
        step();
        word_valid = 1'b0;
        chk("full_bits", 64'(bit_count), 64'd64);
        consume_en  = 1'b1;
        consume_len = 6'd33;
        step();
        consume_en = 1'b0;
        chk("ill33_err",   64'(err),              64'd1);
        chk("ill33_bits",  64'(bit_count),        64'd64);
        chk("ill33_win",   64'(bitstream_output), 64'h01234567);
        chk("ill33_total", 64'(consumed_total),   64'd0);
        // Clear wins over an offered word.
        clear      = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'hFFFFFFFF;
        step();
        clear      = 1'b0;
        word_valid = 1'b0;
        chk("clr3_err",  64'(err),              64'd0);
        chk("clr3_bits", 64'(bit_count),        64'd0);
        chk("clr3_win",  64'(bitstream_output), 64'd0);

        // Reach 48 bits, then async reset between edges.
        word_valid = 1'b1;
        word_data  = 32'hCAFEF00D;
        step();
        consume_en  = 1'b1;
        consume_len = 6'd16;
        word_data   = 32'h11223344;
        step();
        consume_en = 1'b0;
        word_valid = 1'b0;
        chk("b48_bits", 64'(bit_count),        64'd48);
        chk("b48_win",  64'(bitstream_output), 64'hF00D1122);
        chk("b48_total", 64'(consumed_total),  64'd16);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("areset");
        #1;
        reset_n = 1'b1;
        step();
        word_valid = 1'b1;
        word_data  = 32'h55AA55AA;
        step();
        word_valid = 1'b0;
        chk("post_win",  64'(bitstream_output), 64'h55AA55AA);
        chk("post_bits", 64'(bit_count),        64'd32);
        chk("post_wvld", 64'(window_valid),     64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quic_bit_window.md
# quic_bit_window

Upstream bit-alignment stage of the QUIC decoder. Accepts 32-bit compressed words from the input word stream and presents a continuously MSB-aligned 32-bit look-ahead window to the decode stages (run/MELCODE, Golomb). Each cycle the window can be advanced by 0..32 bits, as reported by the active decode stage. The block refills itself from the word stream without bubbles at a sustained consumption of up to 32 bits/cycle.

## Interface
- No parameters; widths fixed: word 32, window 32, internal buffer 64.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush (asserted by the decoder in its set/init state); empties buffer, clears error.
- word_valid  in  1  word_data holds a valid stream word.
- word_data  in  32  next compressed word; bit 31 is the first bit of the stream.
- word_ready  out  1  block accepts word_data this cycle.
- consume_en  in  1  advance the window this cycle.
- consume_len  in  6  bits to advance, legal 0..32.
- bitstream_output  out  32  window; bit 31 = next unconsumed bit.
- window_valid  out  1  at least 32 valid bits buffered (bits >= 32).
- bit_count  out  7  valid bits currently buffered, 0..64.
- consumed_total  out  32  running count of consumed bits since reset/clear, wraps mod 2^32.
- err  out  1  sticky illegal-consume flag.

## Operation
- State: buf[63:0], bits[6:0], consumed_total, err. Valid bits occupy buf[63:64-bits]; bits below are zero.
- bitstream_output = buf[63:32] (combinational from registers). When bits < 32, the low 32-bits positions read 0.
- window_valid = (bits >= 32); word_ready = (bits <= 32); both decoded from registered bits only (no combinational path from consume_* or word_valid).
- Legal consume: consume_en && window_valid && consume_len <= 32. Then len_eff = consume_len, else len_eff = 0.
- Illegal consume: consume_en && (!window_valid || consume_len > 32) → err <= 1, no advance, buffer otherwise updated normally (refill still happens).
- Per-cycle update, consume first then refill:
  - buf_s = buf << len_eff (zero fill); bits_s = bits - len_eff.
  - Accept = word_valid && word_ready. If accept: buf <= buf_s | ({word_data, 32'b0} >> bits_s); bits <= bits_s + 32. Else buf <= buf_s, bits <= bits_s.
  - consumed_total <= consumed_total + len_eff.
- Since word_ready requires bits <= 32 and bits_s <= bits, bits_s + 32 <= 64: no overflow possible.
- consume_len = 0 with consume_en is legal and a no-op (no err).
- clear (sync, priority over everything except reset): buf <= 0, bits <= 0, consumed_total <= 0, err <= 0; any word offered that cycle is not accepted (word_ready still reflects registered bits, but the accept is discarded — the producer must treat clear as a stream restart).

## Timing
- Reset values: buf 0, bits 0, bitstream_output 0, window_valid 0, word_ready 1, bit_count 0, consumed_total 0, err 0.
- Startup latency: first word accepted in cycle N → bits = 32, window_valid = 1 in cycle N+1. Second word accepted in N+1 (bits = 32 ≤ 32) → bits = 64 in N+2.
- Consume-to-window latency: 1 cycle; window presented in cycle N+1 reflects consume of cycle N and any word accepted in cycle N.
- Sustained throughput: with word_valid held high and consume 32/cycle, bits stays at 32 and window_valid stays 1 every cycle.
- Simultaneous consume + accept in one cycle is normal operation; accept always inserts behind the post-consume residue.
- word_data must stay stable while word_valid && !word_ready (standard valid/ready; block never drops an accepted word).
- Reset asserted mid-stream: all state returns to reset values immediately (async); no partial word retained.

## Test plan
- Reset/fill: release reset, offer 0xA5A5A5A5 then 0x0F0F0F0F → cycle+1 window 0xA5A5A5A5, bits 32; cycle+2 bits 64, word_ready 0.
- Unaligned consume: buffer {0xA5A5A5A5,0x0F0F0F0F}, consume 4 → window 0x5A5A5A50, bits 60, consumed_total 4; consume 28 more → window 0x0F0F0F0F, bits 32.
- Streaming: word_valid held with incrementing words 0,1,2..., consume 32 every cycle → window equals successive words, window_valid never drops, no err.
- Mixed lengths with refill: repeat consume 7 over random stream for 100 cycles → window always equals golden bit-serial model at offset consumed_total.
- Illegal consume: bits = 16, consume_en with len 5 → err 1, bits unchanged (16); consume_len 33 at bits 64 → err 1, no advance; clear → err 0, bits 0.
- Async reset mid-stream at bits 48 → all outputs immediately at reset values; next offered word appears as window one cycle after acceptance.
